// File: rtl/hall_enc_pkg.sv
// -----------------------------------------------------------------------------
// hall_enc_pkg
// Shared constants and helpers for the Hall encoder monitor:
//   - sector codes 0..5 and the illegal-sector code (7)
//   - bit positions inside encoder_error_data
//   - Hall pattern -> sector decode and modulo-6 sector stepping
// -----------------------------------------------------------------------------
package hall_enc_pkg;

  localparam logic [2:0] SECT_0       = 3'd0;
  localparam logic [2:0] SECT_1       = 3'd1;
  localparam logic [2:0] SECT_2       = 3'd2;
  localparam logic [2:0] SECT_3       = 3'd3;
  localparam logic [2:0] SECT_4       = 3'd4;
  localparam logic [2:0] SECT_5       = 3'd5;
  localparam logic [2:0] SECT_ILLEGAL = 3'd7;

  localparam int ERR_ILLEGAL = 0;
  localparam int ERR_SKIP    = 1;
  localparam int ERR_UVW     = 2;
  localparam int ERR_ABZ     = 3;
  localparam int ERR_TMO     = 4;
  localparam int ERR_ANY     = 5;
  localparam int ERR_SRC_N   = 5;

  typedef struct packed {
    logic       valid;
    logic [2:0] sector;
  } sector_t;

  // Filtered {w,v,u} -> sector; 000 and 111 cannot occur on a healthy sensor.
  function automatic sector_t hall_to_sector(input logic [2:0] hall);
    sector_t s;
    s.valid  = 1'b1;
    s.sector = SECT_ILLEGAL;
    case (hall)
      3'b001:  s.sector = SECT_0;
      3'b011:  s.sector = SECT_1;
      3'b010:  s.sector = SECT_2;
      3'b110:  s.sector = SECT_3;
      3'b100:  s.sector = SECT_4;
      3'b101:  s.sector = SECT_5;
      default: s.valid  = 1'b0;
    endcase
    return s;
  endfunction

  function automatic logic [2:0] sector_inc(input logic [2:0] s);
    return (s == SECT_5) ? SECT_0 : s + 3'd1;
  endfunction

  function automatic logic [2:0] sector_dec(input logic [2:0] s);
    return (s == SECT_0) ? SECT_5 : s - 3'd1;
  endfunction

endpackage

// File: rtl/hall_debounce.sv
// -----------------------------------------------------------------------------
// hall_debounce
// Two-flop synchroniser followed by a stability filter for one asynchronous
// line. The filtered output follows the synchronised value only after it has
// differed from the current filtered value for DEB_CNT consecutive cycles;
// any return to the filtered value restarts the count.
//
// Ports:
//   clk_in    system clock
//   rst_n_in  synchronous active-low reset (clears sync, count and output)
//   din_i     raw asynchronous input
//   filt_o    debounced, synchronous output
// -----------------------------------------------------------------------------
module hall_debounce #(
  parameter int DEB_CNT = 4
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic din_i,
  output logic filt_o
);

  localparam logic [7:0] DEB_MAX = 8'(DEB_CNT);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       filt_q,  filt_d;
  logic [7:0] cnt_q,   cnt_d;

  always_comb begin
    sync1_d = din_i;
    sync2_d = sync1_q;
    filt_d  = filt_q;
    cnt_d   = '0;
    if (sync2_q != filt_q) begin
      // The count register must already hold DEB_CNT before the output moves,
      // giving a fixed sync(2) + count(DEB_CNT) + update(1) latency.
      if (cnt_q == DEB_MAX) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/hall_encoder_monitor.sv
// -----------------------------------------------------------------------------
// hall_encoder_monitor
// Debounces three Hall lines and two cable-present lines, decodes the Hall
// state into a commutation sector, tracks rotation direction and raises
// sticky error flags.
//
// Optional feature: define HALL_TIMEOUT_EN to build the stall-timeout counter
// (error bit 4). Without it no counter exists and bit 4 is tied to 0.
//
// Ports:
//   clk_in              system clock, rising edge
//   rst_n_in            synchronous active-low reset
//   enc_u/enc_v/enc_w   raw Hall lines (asynchronous)
//   uvw, abz            cable-present lines (asynchronous, 1 = present)
//   clr_err             one-cycle request to clear sticky error flags
//   edge_pulse          one-cycle strobe per accepted Hall state change
//   uvw_data            [2:0] filtered {w,v,u}, [5:3] sector, [6] dir,
//                       [7] sector valid
//   encoder_error_data  [0] illegal state, [1] sequence skip, [2] uvw absent,
//                       [3] abz absent, [4] stall timeout, [5] any, [7:6] 0
// -----------------------------------------------------------------------------
module hall_encoder_monitor
  import hall_enc_pkg::*;
#(
  parameter int DEB_CNT    = 4,
  parameter int TMO_W      = 16,
  parameter int TMO_CYCLES = 50000
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       enc_u,
  input  logic       enc_v,
  input  logic       enc_w,
  input  logic       uvw,
  input  logic       abz,
  input  logic       clr_err,
  output logic       edge_pulse,
  output logic [7:0] uvw_data,
  output logic [7:0] encoder_error_data
);

  // Cycles after reset until every filter can reflect its real input level.
  localparam logic [8:0] SETTLE_CYC = 9'(DEB_CNT + 3);

  logic [4:0] raw_in;
  logic [4:0] filt;
  logic [2:0] hall_filt;

  logic [7:0] uvw_data_q, uvw_data_d;
  logic [7:0] err_q,      err_d;
  logic       edge_q,     edge_d;
  logic [8:0] settle_q,   settle_d;

  logic       settled;
  logic       hall_chg;
  logic       prev_valid;
  logic [2:0] prev_sector;
  logic       dir_d;
  logic       skip_det;
  logic       tmo_hit;
  logic [ERR_SRC_N-1:0] err_set;
  sector_t    cur;

  assign raw_in = {abz, uvw, enc_w, enc_v, enc_u};

  for (genvar i = 0; i < 5; i++) begin : g_deb
    hall_debounce #(
      .DEB_CNT (DEB_CNT)
    ) u_deb (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .din_i    (raw_in[i]),
      .filt_o   (filt[i])
    );
  end

  assign hall_filt = filt[2:0];
  assign cur       = hall_to_sector(hall_filt);

  // The registered output doubles as the "previous" state: reset clears its
  // valid bit, so the first sector after reset or after an illegal state is
  // accepted without a sequence check.
  assign prev_valid  = uvw_data_q[7];
  assign prev_sector = uvw_data_q[5:3];
  assign hall_chg    = (hall_filt != uvw_data_q[2:0]);

  // Filters all read 0 straight out of reset; level checks (illegal state,
  // cable absent) are blanked until the filters have had time to acquire.
  assign settled = (settle_q == SETTLE_CYC);

  always_comb begin
    settle_d = settled ? settle_q : settle_q + 9'd1;
    dir_d    = uvw_data_q[6];
    skip_det = 1'b0;
    if (hall_chg && cur.valid && prev_valid) begin
      if (cur.sector == sector_inc(prev_sector)) begin
        dir_d = 1'b1;
      end else if (cur.sector == sector_dec(prev_sector)) begin
        dir_d = 1'b0;
      end else begin
        skip_det = 1'b1;
      end
    end
    uvw_data_d = {cur.valid, dir_d, cur.sector, hall_filt};
    edge_d     = hall_chg;
  end

`ifdef HALL_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TMO_CYCLES);

  logic [TMO_W-1:0] tmo_q, tmo_d;

  always_comb begin
    tmo_d = tmo_q;
    if (edge_q) begin
      tmo_d = '0;
    end else if (tmo_q != TMO_MAX) begin
      tmo_d = tmo_q + TMO_W'(1);
    end
  end

  // Saturated count keeps asserting, so the flag re-sets while still stalled.
  assign tmo_hit = (tmo_d == TMO_MAX);

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  // An out-of-range threshold leaves tmo_hit undriven so lint rejects the
  // configuration even when the counter is not built.
  if ((TMO_CYCLES >> TMO_W) == 0) begin : g_tmo_off
    assign tmo_hit = 1'b0;
  end
`endif

  always_comb begin
    err_set              = '0;
    err_set[ERR_ILLEGAL] = settled && !cur.valid;
    err_set[ERR_SKIP]    = skip_det;
    err_set[ERR_UVW]     = settled && !filt[3];
    err_set[ERR_ABZ]     = settled && !filt[4];
    err_set[ERR_TMO]     = tmo_hit;
    err_d                = '0;
    // A fresh detection wins over a simultaneous clear.
    err_d[ERR_SRC_N-1:0] = err_set | (err_q[ERR_SRC_N-1:0] & {ERR_SRC_N{~clr_err}});
    err_d[ERR_ANY]       = |err_d[ERR_SRC_N-1:0];
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      uvw_data_q <= '0;
      err_q      <= '0;
      edge_q     <= 1'b0;
      settle_q   <= '0;
    end else begin
      uvw_data_q <= uvw_data_d;
      err_q      <= err_d;
      edge_q     <= edge_d;
      settle_q   <= settle_d;
    end
  end

  assign uvw_data           = uvw_data_q;
  assign encoder_error_data = err_q;
  assign edge_pulse         = edge_q;

endmodule

// File: tb/tb_hall_encoder_monitor.sv
// -----------------------------------------------------------------------------
// tb_hall_encoder_monitor
// Directed bench for hall_encoder_monitor (DEB_CNT=4, TMO_CYCLES=100).
// Expected values are hand-computed uvw_data / error bytes.
// -----------------------------------------------------------------------------
module tb_hall_encoder_monitor;

  logic       clk_in = 1'b0;
  logic       rst_n_in;
  logic       enc_u, enc_v, enc_w;
  logic       uvw, abz;
  logic       clr_err;
  logic       edge_pulse;
  logic [7:0] uvw_data;
  logic [7:0] encoder_error_data;

  int n_chk   = 0;
  int n_bad   = 0;
  int n_edges = 0;
  int e0;
  int w;

`ifdef HALL_TIMEOUT_EN
  localparam logic [7:0] TMO_ERR = 8'h30;
`else
  localparam logic [7:0] TMO_ERR = 8'h00;
`endif

  logic [2:0] fwd_h [6] = '{3'b011, 3'b010, 3'b110, 3'b100, 3'b101, 3'b001};
  logic [7:0] fwd_u [6] = '{8'hCB, 8'hD2, 8'hDE, 8'hE4, 8'hED, 8'hC1};

  always #5 clk_in = ~clk_in;

  hall_encoder_monitor #(
    .DEB_CNT    (4),
    .TMO_W      (16),
    .TMO_CYCLES (100)
  ) dut (
    .clk_in             (clk_in),
    .rst_n_in           (rst_n_in),
    .enc_u              (enc_u),
    .enc_v              (enc_v),
    .enc_w              (enc_w),
    .uvw                (uvw),
    .abz                (abz),
    .clr_err            (clr_err),
    .edge_pulse         (edge_pulse),
    .uvw_data           (uvw_data),
    .encoder_error_data (encoder_error_data)
  );

  always @(negedge clk_in) begin
    if (edge_pulse === 1'b1) n_edges++;
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%02h exp=%02h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic set_hall(input logic [2:0] h);
    {enc_w, enc_v, enc_u} = h;
  endtask

  task automatic clr_pulse();
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n_in = 1'b0;
    set_hall(3'b001);
    uvw      = 1'b1;
    abz      = 1'b1;
    clr_err  = 1'b0;
    tick(3);
    chk("rst_uvw",  uvw_data, 8'h00);
    chk("rst_err",  encoder_error_data, 8'h00);
    chk("rst_edge", {7'b0, edge_pulse}, 8'h00);

    rst_n_in = 1'b1;
    tick(20);
    chk("acq_uvw", uvw_data, 8'h81);
    chk("acq_err", encoder_error_data, 8'h00);

    // forward rotation 0 -> 1 -> ... -> 5 -> 0
    e0 = n_edges;
    for (int i = 0; i < 6; i++) begin
      set_hall(fwd_h[i]);
      tick(20);
      chk($sformatf("fwd%0d", i), uvw_data, fwd_u[i]);
    end
    chk("fwd_edges", 8'(n_edges - e0), 8'd6);
    chk("fwd_err", encoder_error_data, 8'h00);

    // reverse 0 -> 5 (wrap) with exact latency, then 4, 3
    set_hall(3'b101);
    tick(7);
    chk("lat_pre_edge", {7'b0, edge_pulse}, 8'h00);
    chk("lat_pre_uvw",  uvw_data, 8'hC1);
    tick(1);
    chk("lat_edge", {7'b0, edge_pulse}, 8'h01);
    chk("rev5",     uvw_data, 8'hAD);
    tick(1);
    chk("lat_one",  {7'b0, edge_pulse}, 8'h00);
    tick(17);
    set_hall(3'b100);
    tick(20);
    chk("rev4", uvw_data, 8'hA4);
    set_hall(3'b110);
    tick(20);
    chk("rev3", uvw_data, 8'h9E);
    chk("rev_err", encoder_error_data, 8'h00);

    // jump 3 -> 0 is a skip; dir holds
    set_hall(3'b001);
    tick(20);
    chk("jump_uvw", uvw_data, 8'h81);
    chk("jump_err", encoder_error_data, 8'h22);
    clr_pulse();
    chk("jump_clr", encoder_error_data, 8'h00);
    tick(2);

    // illegal 111, then recovery without a sequence check
    set_hall(3'b111);
    tick(10);
    chk("ill_err", encoder_error_data, 8'h21);
    chk("ill_uvw", uvw_data, 8'h3F);
    set_hall(3'b001);
    tick(20);
    chk("ill_rec_uvw", uvw_data, 8'h81);
    chk("ill_rec_err", encoder_error_data, 8'h21);
    clr_pulse();
    chk("ill_clr", encoder_error_data, 8'h00);

    // 3-cycle glitch is swallowed
    e0 = n_edges;
    set_hall(3'b011);
    tick(3);
    set_hall(3'b001);
    tick(15);
    chk("glitch_edges", 8'(n_edges - e0), 8'd0);
    chk("glitch_uvw",   uvw_data, 8'h81);

    // uvw cable absent
    set_hall(3'b011);
    tick(20);
    chk("cab_uvw_data", uvw_data, 8'hCB);
    uvw = 1'b0;
    tick(12);
    chk("uvw_flag", encoder_error_data, 8'h24);
    clr_pulse();
    chk("uvw_reset", encoder_error_data, 8'h24);
    uvw = 1'b1;
    tick(12);
    clr_pulse();
    chk("uvw_clear", encoder_error_data, 8'h00);

    // abz cable absent
    set_hall(3'b010);
    tick(20);
    chk("cab_abz_data", uvw_data, 8'hD2);
    abz = 1'b0;
    tick(12);
    chk("abz_flag", encoder_error_data, 8'h28);
    abz = 1'b1;
    tick(12);
    clr_pulse();
    chk("abz_clear", encoder_error_data, 8'h00);

    // one-cycle reset in the middle of a debounce
    set_hall(3'b110);
    tick(4);
    rst_n_in = 1'b0;
    tick(1);
    chk("mr_uvw",  uvw_data, 8'h00);
    chk("mr_err",  encoder_error_data, 8'h00);
    chk("mr_edge", {7'b0, edge_pulse}, 8'h00);
    rst_n_in = 1'b1;
    e0 = n_edges;
    tick(20);
    chk("mr_acq",   uvw_data, 8'h9E);
    chk("mr_err2",  encoder_error_data, 8'h00);
    chk("mr_edges", 8'(n_edges - e0), 8'd1);

    // stall timeout after the last accepted edge
    set_hall(3'b100);
    w = 0;
    while (edge_pulse !== 1'b1 && w < 20) begin
      tick(1);
      w++;
    end
    chk("tmo_edge", {7'b0, edge_pulse}, 8'h01);
    tick(100);
    chk("tmo_pre", encoder_error_data, 8'h00);
    tick(1);
    chk("tmo_hit", encoder_error_data, TMO_ERR);
    chk("tmo_uvw", uvw_data, 8'hE4);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/hall_encoder_monitor.md
HALL_ENCODER_MONITOR -- requirements
Module: hall_encoder_monitor

Interface
REQ-001 SHALL have parameter DEB_CNT, default 4: consecutive stable cycles a synchronised input must hold before its filtered value updates (range 1..255).
REQ-002 SHALL have parameter TMO_W, default 16: width of the stall-timeout counter.
REQ-003 SHALL have parameter TMO_CYCLES, default 50000: stall-timeout threshold in clk_in cycles (< 2^TMO_W).
REQ-004 clk_in  input  1  sole system clock; all logic on its rising edge.
REQ-005 rst_n_in  input  1  reset; synchronous, active-low.
REQ-006 enc_u, enc_v, enc_w  input  1 each  raw Hall lines, asynchronous.
REQ-007 uvw  input  1  UVW cable-present line, asynchronous, 1 = present.
REQ-008 abz  input  1  ABZ cable-present line, asynchronous, 1 = present.
REQ-009 clr_err  input  1  one-cycle request to clear sticky error flags.
REQ-010 edge_pulse  output  1  one-cycle strobe on each accepted Hall state change.
REQ-011 uvw_data  output  8  [2:0] filtered {w,v,u}, [5:3] sector, [6] dir, [7] sector_valid.
REQ-012 encoder_error_data  output  8  sticky error flags (REQ-019).

Function
REQ-013 SHALL pass each of the 5 inputs through a 2-FF synchroniser, then a debounce filter: per-input counter increments while synced != filtered, clears when equal; filtered takes synced value when counter reaches DEB_CNT.
REQ-014 SHALL map filtered {w,v,u}: 001->0, 011->1, 010->2, 110->3, 100->4, 101->5; 000/111 -> sector 7, sector_valid=0.
REQ-015 All outputs SHALL be registered; a clean pin change reaches uvw_data and edge_pulse exactly DEB_CNT+3 cycles after the first clock edge sampling the new level.
REQ-016 A filtered Hall change SHALL pulse edge_pulse for exactly one cycle; glitches shorter than DEB_CNT cycles SHALL produce no output change.
REQ-017 Direction: new sector = (old+1) mod 6 -> dir=1; (old-1) mod 6 -> dir=0; dir otherwise holds (5->0 forward and 0->5 reverse are wrap-around, not errors).
REQ-018 If old and new sectors are both valid and differ by neither +1 nor -1 mod 6, SHALL set skip flag; first valid sector after reset or after an illegal state SHALL NOT be checked and SHALL NOT change dir.
REQ-019 encoder_error_data bits: [0] illegal Hall state, [1] sequence skip, [2] filtered uvw=0, [3] filtered abz=0, [4] stall timeout, [5] OR of [4:0], [7:6] constant 0.
REQ-020 Bits [4:0] SHALL be sticky, set on the cycle the condition is detected, cleared by clr_err the next cycle; set condition in the same cycle as clr_err SHALL win (flag stays 1).
REQ-021 Bits [2]/[3] SHALL re-set on the cycle after clr_err while the cable remains absent.

Reset
REQ-022 While rst_n_in=0 at a clock edge: synchronisers, filtered values, debounce and timeout counters, uvw_data, encoder_error_data, edge_pulse SHALL become 0; "previous sector" SHALL become invalid.
REQ-023 Reset asserted mid-debounce or mid-timeout SHALL discard partial counts; no edge_pulse SHALL be generated by the reset itself.

Configuration
REQ-024 With HALL_TIMEOUT_EN defined: counter increments every cycle, clears on edge_pulse, saturates at TMO_CYCLES, and sets bit [4] when it reaches TMO_CYCLES.
REQ-025 Without HALL_TIMEOUT_EN: no timeout counter SHALL be synthesised; bit [4] SHALL be constant 0.

Structure
REQ-026 Package hall_enc_pkg SHALL hold sector code constants, illegal-sector code (7), and error-bit index constants.
REQ-027 Sub-module hall_debounce (sync + filter, parameter DEB_CNT) SHALL be instantiated once per input (5 instances).

Verification
REQ-028 Forward sequence 001,011,010,110,100,101,001 each held 20 cycles -> 6 edge_pulses, sectors 0..5,0, dir=1, error bits 0.
REQ-029 Reverse sequence 101,100,110 -> sectors 5,4,3, dir=0, no skip flag.
REQ-030 Jump 001->110 -> skip bit [1]=1, bit [5]=1; clr_err pulse -> [1] returns to 0 next cycle.
REQ-031 Hall=111 for 10 cycles -> bit [0]=1, uvw_data[7]=0; 3-cycle glitch with DEB_CNT=4 -> no edge_pulse, no output change.
REQ-032 uvw=0 held -> bit [2]=1, re-sets after clr_err; with HALL_TIMEOUT_EN, TMO_CYCLES=100 and no Hall change -> bit [4]=1 at cycle 100.
REQ-033 rst_n_in=0 for 1 cycle mid-sequence -> all outputs 0 next cycle; next valid sector sets no skip flag.
